// File: rtl/truth_table_sweeper_if.sv
// Bus between the sweeper and its surroundings: control/result signals
// toward the lab controller plus the drive/sense pair toward the gate circuit.
interface truth_table_sweeper_if #(
    parameter int N_IN = 3
);
    logic                    start;
    logic [(1<<N_IN)-1:0]    expected_tt;
    logic                    dut_out;
    logic [N_IN-1:0]         dut_in;
    logic                    busy;
    logic                    done;
    logic                    pass;
    logic [N_IN:0]           err_count;
    logic                    first_err_valid;
    logic [N_IN-1:0]         first_err_idx;

    // Controller / environment side
    modport master (
        output start, expected_tt, dut_out,
        input  dut_in, busy, done, pass, err_count, first_err_valid, first_err_idx
    );

    // Sweeper side
    modport slave (
        input  start, expected_tt, dut_out,
        output dut_in, busy, done, pass, err_count, first_err_valid, first_err_idx
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: walks dut_in through every code, holds each
// vector HOLD_CYCLES cycles, samples dut_out on the last held cycle and
// compares it against a golden table latched at start.
module truth_table_sweeper #(
    parameter int N_IN        = 3,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    truth_table_sweeper_if.slave         bus
);
    localparam int                NV        = 1 << N_IN;
    localparam int                HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0]     HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [N_IN-1:0]   LAST_VEC  = '1;
    localparam logic [N_IN:0]     ERR_MAX   = (N_IN+1)'(NV);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t            state_q, state_d;
    logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
    logic [NV-1:0]     tt_q, tt_d;
    logic [N_IN-1:0]   dut_in_q, dut_in_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [N_IN:0]     err_count_q, err_count_d;
    logic              fev_q, fev_d;
    logic [N_IN-1:0]   fei_q, fei_d;
    logic              mismatch;

    // Next-state and result update; the sample happens only on the last held cycle
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        tt_d        = tt_q;
        dut_in_d    = dut_in_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        err_count_d = err_count_q;
        fev_d       = fev_q;
        fei_d       = fei_q;
        mismatch    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    tt_d        = bus.expected_tt;
                    dut_in_d    = '0;
                    hold_cnt_d  = '0;
                    busy_d      = 1'b1;
                    err_count_d = '0;
                    fev_d       = 1'b0;
                    fei_d       = '0;
                    pass_d      = 1'b0;
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                if (hold_cnt_q != HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end else begin
                    mismatch = (bus.dut_out != tt_q[dut_in_q]);
                    if (mismatch) begin
                        if (err_count_q != ERR_MAX) err_count_d = err_count_q + 1'b1;
                        if (!fev_q) begin
                            fev_d = 1'b1;
                            fei_d = dut_in_q;
                        end
                    end
                    hold_cnt_d = '0;
                    if (dut_in_q != LAST_VEC) begin
                        dut_in_d = dut_in_q + 1'b1;
                    end else begin
                        // Final sample: pass needs a clean history and a clean last sample
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        dut_in_d = '0;
                        pass_d   = !fev_q && !mismatch;
                        state_d  = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers; reset aborts any sweep without a done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            hold_cnt_q  <= '0;
            tt_q        <= '0;
            dut_in_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= '0;
            fev_q       <= 1'b0;
            fei_q       <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            tt_q        <= tt_d;
            dut_in_q    <= dut_in_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_count_q <= err_count_d;
            fev_q       <= fev_d;
            fei_q       <= fei_d;
        end
    end

    assign bus.dut_in          = dut_in_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.pass            = pass_q;
    assign bus.err_count       = err_count_q;
    assign bus.first_err_valid = fev_q;
    assign bus.first_err_idx   = fei_q;
endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Exhaustive stimulus generator and response checker for the lab's combinational gate circuits (NOT/AND/OR networks of 1-8 inputs).
- Drives every input combination onto the circuit under test, holds each vector for a fixed settle time and samples the single output.
- Compares each sample against a golden truth table and reports pass/fail, error count and the first failing vector.
- Sits directly upstream of the circuit (feeds its inputs) and consumes its output.

Parameters:
- N_IN, 3, number of DUT inputs; legal 1..8.
- HOLD_CYCLES, 4, clock cycles each vector is held before its sample; legal >= 1.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- expected_tt  input  2**N_IN  golden table; bit i = expected output when dut_in == i. Latched at start.
- dut_out  input  1  output of the circuit under test.
- dut_in  output  N_IN  vector driven to the DUT; bit 0 = the circuit's input1, bit 1 = input2, and so on.
- busy  output  1  sweep in progress.
- done  output  1  one-cycle pulse at sweep end.
- pass  output  1  last sweep had zero mismatches; valid from done until the next start.
- err_count  output  N_IN+1  mismatches in the last or current sweep; saturates at 2**N_IN.
- first_err_valid  output  1  at least one mismatch so far.
- first_err_idx  output  N_IN  dut_in value of the first mismatch; 0 when first_err_valid = 0.

Behaviour:
- Reset: asynchronous, active-low. All outputs go to 0, state goes to IDLE, tt_q is cleared.
- States: IDLE and RUN. Internal registers: hold_cnt, width clog2(HOLD_CYCLES) (minimum 1), and tt_q.
- IDLE, start = 1 at an edge:
  - tt_q <= expected_tt; dut_in <= 0; hold_cnt <= 0; busy <= 1.
  - err_count, first_err_valid, first_err_idx and pass are all cleared to 0.
  - Next state is RUN.
- RUN, each edge with hold_cnt < HOLD_CYCLES-1: hold_cnt increments.
- RUN, edge with hold_cnt == HOLD_CYCLES-1 (sample edge):
  - Mismatch is defined as dut_out != tt_q[dut_in].
  - On a mismatch, err_count increments.
  - On a mismatch with first_err_valid = 0, first_err_idx <= dut_in and first_err_valid <= 1.
  - If dut_in != 2**N_IN-1: dut_in increments and hold_cnt <= 0.
  - If dut_in == 2**N_IN-1: busy <= 0, done <= 1, dut_in <= 0, and state goes to IDLE.
  - At that final edge, pass <= 1 only if there was no earlier mismatch and this last sample also matches.
- Timing: vector v is driven for exactly HOLD_CYCLES cycles. busy is high for exactly 2**N_IN * HOLD_CYCLES cycles. done rises on the same edge that busy falls.
- done: a single-cycle pulse, cleared on the following edge.
- Result hold: pass, err_count and the first_err signals hold their values in IDLE until the next start.
- start while in RUN: ignored; the sweep is not restarted.
- start = 1 in the done cycle: a new sweep begins at that edge. done still clears on the following edge, and the results clear as for any start.
- expected_tt changes during RUN: no effect, because only tt_q is used.
- dut_out is treated as combinational from dut_in; no synchronizer. It is sampled at the sample edge only, so with HOLD_CYCLES = 1 the sample is taken one cycle after the vector is applied.
- rst_n low in mid-sweep: the sweep is aborted immediately and all outputs return to 0. There is no done pulse.

Test Plan:
1. 2-input XOR (c'd + cd'). N_IN=2, HOLD_CYCLES=4, expected_tt=4'b0110, start one cycle.
   - dut_in steps 0,1,2,3, 4 cycles each; busy high for 16 cycles.
   - done pulses once; pass=1, err_count=0, first_err_valid=0.
2. Absorption a+ab used as a = input1. N_IN=2, expected_tt=4'b1010, DUT stuck-at-0.
   - err_count=2, first_err_idx=1, first_err_valid=1, pass=0.
3. (a'+b')(a+c') with a=bit0, b=bit1, c=bit2. N_IN=3, HOLD_CYCLES=1, expected_tt=8'h27, correct DUT.
   - 8 busy cycles, pass=1.
   - Same run with DUT output inverted: err_count=8 (saturation value), first_err_idx=0.
4. Start ignored while busy. Pulse start again at busy cycle 5 of scenario 1.
   - The sweep is not restarted: total busy time is still 16 cycles and there is only one done pulse.
5. Reset mid-run. Drop rst_n on cycle 7 of a sweep.
   - All outputs read 0 immediately and there is no done pulse.
   - After release, a fresh start completes a normal sweep.
6. Back-to-back runs. Hold start high through the done cycle.
   - A second sweep starts on the same edge that done falls.
   - err_count and pass from the first run are cleared, and done clears on the next edge.
